alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle RV64M divide/remainder unit; sits beside the single-cycle ALU in the execute stage.
- Takes the same 64-bit operand pair and `is_32bit` qualifier as the ALU.
- Executes DIV, DIVU, REM, REMU and their W forms with a radix-2 restoring algorithm.
- Uses a valid/ready handshake so the pipeline can stall on it.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- CNT_W, 7, width of the iteration counter (must hold XLEN).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request presented
- in_ready  output  1  unit idle, can accept a request
- div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- is_32bit  input  1  W form: use bits [31:0] of both operands; result sign-extended from bit 31
- input_div_A  input  64  dividend (rs1)
- input_div_B  input  64  divisor (rs2)
- flush  input  1  abort any in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- div_result  output  64  quotient or remainder
- div_busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, div_busy=0, div_result=0, internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept on the edge where in_valid && in_ready.
  - Latch op, is_32bit and operand magnitudes (signed ops: absolute value; W forms: from the 32-bit sign-extended operand).
  - Record quotient sign = sA^sB and remainder sign = sA.
  - Counter loaded with N: 64, or 32 for W forms.
  - Special cases detected at acceptance go straight to DONE, bypassing CALC/FIX:
    - B==0 (effective width): quotient = all ones; remainder = A. W forms sign-extend the 32-bit value.
    - Signed overflow (A = most-negative, B = -1; effective width): quotient = A, remainder = 0.
  - Otherwise go to CALC.
- CALC:
  - One restoring step per cycle: shift {rem,quo} left 1; trial subtract divisor; commit if non-negative; set quo LSB.
  - Counter decrements; the cycle the counter reaches 1 transitions to FIX.
- FIX:
  - Apply sign correction by two's-complement negation where required.
  - Select quotient or remainder.
  - For W forms, sign-extend bit 31 to 64.
  - Register div_result; go to DONE.
- DONE:
  - out_valid=1, div_result stable.
  - On out_valid && out_ready, go to IDLE; out_valid drops on that edge.
  - No new request is accepted in the same cycle: in_ready=1 only in IDLE.
- Latency, counted from the accepting edge to the edge after which out_valid is high:
  - Normal 64-bit: N+2 = 66.
  - W form: 34.
  - Special case: 1.
- Throughput: one operation in flight; in_ready=0 in CALC/FIX/DONE.
- flush:
  - Highest priority after rst.
  - Any state returns to IDLE on the next edge; out_valid=0; div_result unchanged.
  - flush in IDLE together with in_valid: the request is dropped, not accepted.
- rst mid-operation: identical to reset values on the next edge; no partial result emitted.
- Backpressure: out_ready held low keeps DONE indefinitely with div_result and out_valid constant.
- Operands are not required stable after the accepting edge.

Optional Feature:
- Macro: ALU_DIV_EARLY_OUT_EN.
- Defined:
  - At acceptance, if |A| < |B| (unsigned magnitude, effective width, B≠0), skip CALC/FIX and go to DONE with latency 1.
  - Results: quotient 0; remainder = original A (sign-extended for W).
- Undefined: such operands take the full N+2 latency and produce the same values.

Test Plan:
- DIVU, A=100, B=7, 64-bit -> div_result=14, out_valid rises 66 edges after acceptance; REMU with the same operands -> 2.
- DIV, A=-7, B=2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3); REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- Division by zero:
  - DIV A=0x1234, B=0 -> 0xFFFF_FFFF_FFFF_FFFF in 1 edge.
  - REMW A=0x0000_0000_8000_0001, B=0 -> 0xFFFF_FFFF_8000_0001.
- Overflow:
  - DIV A=0x8000_0000_0000_0000, B=-1 -> 0x8000_0000_0000_0000.
  - DIVW A=0x8000_0000, B=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
  - REM of the same 64-bit pair -> 0.
- DIVW, A=0xFFFF_FFFF_0000_0010, B=3 (low words 16/3) -> 5, latency 34; hold out_ready=0 for 10 cycles -> result and out_valid stable, then IDLE one edge after out_ready=1.
- Flush and reset:
  - Assert flush 20 cycles into a 64-bit DIVU -> next edge in_ready=1, out_valid never asserts; a new DIVU 9/3 then returns 3.
  - Repeat with rst instead of flush -> same, with div_result=0.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the sequential RV64M divider.
interface alu_muldiv_seq_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      div_op;
    logic            is_32bit;
    logic [XLEN-1:0] input_div_A;
    logic [XLEN-1:0] input_div_B;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] div_result;
    logic            div_busy;

    modport master (
        output in_valid, div_op, is_32bit, input_div_A, input_div_B, flush, out_ready,
        input  in_ready, out_valid, div_result, div_busy
    );

    modport slave (
        input  in_valid, div_op, is_32bit, input_div_A, input_div_B, flush, out_ready,
        output in_ready, out_valid, div_result, div_busy
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Radix-2 restoring DIV/DIVU/REM/REMU (+W forms) with valid/ready handshake.
// Optional macro ALU_DIV_EARLY_OUT_EN: finish in one edge when |A| < |B|.
module alu_muldiv_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input logic             clk,
    input logic             rst,
    alu_muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] N64    = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] N32    = CNT_W'(32);
    localparam logic [XLEN-1:0]  MIN64  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  MIN32  = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    state_t           state_q;
    logic [XLEN-1:0]  rem_q, quo_q, divisor_q, result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             isW_q, isRem_q, negQ_q, negR_q;
    logic             inReady_q, outValid_q, busy_q;

    logic            signedOp, isRem, sA, sB, bZero, overflow, earlyOut;
    logic [XLEN-1:0] effA, effB, magA, magB, specVal;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] qFix, rFix, sel, fixVal;

    // Acceptance-time decode: effective operands, magnitudes and the one-edge special cases.
    always_comb begin
        signedOp = ~bus.div_op[0];
        isRem    = bus.div_op[1];
        effA     = bus.is_32bit ? {{(XLEN-32){bus.input_div_A[31]}}, bus.input_div_A[31:0]}
                                : bus.input_div_A;
        effB     = bus.is_32bit ? {{(XLEN-32){bus.input_div_B[31]}}, bus.input_div_B[31:0]}
                                : bus.input_div_B;
        sA       = signedOp & effA[XLEN-1];
        sB       = signedOp & effB[XLEN-1];
        magA     = sA ? -effA : effA;
        magB     = sB ? -effB : effB;
        bZero    = (effB == '0);
        overflow = signedOp && (effA == (bus.is_32bit ? MIN32 : MIN64)) && (effB == '1);
`ifdef ALU_DIV_EARLY_OUT_EN
        earlyOut = !bZero && (magA < magB);
`else
        earlyOut = 1'b0;
`endif
        if (bZero)
            specVal = isRem ? effA : '1;
        else if (overflow)
            specVal = isRem ? '0 : effA;
        else
            specVal = isRem ? effA : '0;
    end

    // One restoring step; rem always stays below the divisor so a 65-bit trial suffices.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, divisor_q};
        qFix    = negQ_q ? -quo_q : quo_q;
        rFix    = negR_q ? -rem_q : rem_q;
        sel     = isRem_q ? rFix : qFix;
        fixVal  = isW_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            isW_q      <= 1'b0;
            isRem_q    <= 1'b0;
            negQ_q     <= 1'b0;
            negR_q     <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (bus.flush) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        isW_q     <= bus.is_32bit;
                        isRem_q   <= isRem;
                        negQ_q    <= sA ^ sB;
                        negR_q    <= sA;
                        rem_q     <= '0;
                        // W dividends sit in the top half so the MSB feed is always bit XLEN-1.
                        quo_q     <= bus.is_32bit ? {magA[31:0], 32'b0} : magA;
                        divisor_q <= magB;
                        cnt_q     <= bus.is_32bit ? N32 : N64;
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (bZero || overflow || earlyOut) begin
                            result_q   <= specVal;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_q <= FIX;
                end
                FIX: begin
                    result_q   <= fixVal;
                    outValid_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = inReady_q;
    assign bus.out_valid  = outValid_q;
    assign bus.div_result = result_q;
    assign bus.div_busy   = busy_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq: results, latencies, backpressure, flush and reset.
module tb_alu_muldiv_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   lat;
    logic saw;
    logic stable;

    always #5 clk = ~clk;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef ALU_DIV_EARLY_OUT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 66;
`endif

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Present one request, let it be accepted, then scramble the operands.
    task automatic applyStimulus(input logic [1:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
        bus.div_op      = op;
        bus.is_32bit    = w;
        bus.input_div_A = a;
        bus.input_div_B = b;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.div_op      = ~op;
        bus.is_32bit    = ~w;
        bus.input_div_A = {$urandom, $urandom};
        bus.input_div_B = {$urandom, $urandom};
    endtask

    // Latency counts the accepting edge as edge 1.
    task automatic waitResult(output int latency);
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        latency = n + 1;
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] expRes, input int expLat);
        int l;
        applyStimulus(op, w, a, b);
        waitResult(l);
        checkOutput({tag, "_lat"}, 64'(l), 64'(expLat));
        checkOutput({tag, "_res"}, bus.div_result, expRes);
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle"}, {63'b0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.div_op      = 2'b00;
        bus.is_32bit    = 1'b0;
        bus.input_div_A = '0;
        bus.input_div_B = '0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstInReady",  {63'b0, bus.in_ready},  64'd1);
        checkOutput("rstOutValid", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("rstBusy",     {63'b0, bus.div_busy},  64'd0);
        checkOutput("rstResult",   bus.div_result,         64'd0);

        runOp("divu",   2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        runOp("remu",   2'b11, 1'b0, 64'd100, 64'd7, 64'd2,  66);
        runOp("divNeg", 2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        runOp("remNeg", 2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        runOp("divZ",   2'b00, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        runOp("remwZ",  2'b10, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1);
        runOp("divOvf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1);
        runOp("divwOvf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1);
        runOp("remOvf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        runOp("divuwMax", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        runOp("remSmall", 2'b10, 1'b0, 64'd5, -64'sd9, 64'd5, LAT_SMALL);
        runOp("divSmall", 2'b00, 1'b0, 64'd5, -64'sd9, 64'd0, LAT_SMALL);

        // Backpressure on a W-form divide.
        bus.out_ready = 1'b0;
        applyStimulus(2'b00, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3);
        waitResult(lat);
        checkOutput("bpLat", 64'(lat), 64'd34);
        checkOutput("bpRes", bus.div_result, 64'd5);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid || bus.div_result !== 64'd5 || bus.in_ready) stable = 1'b0;
        end
        checkOutput("bpStable", {63'b0, stable}, 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpIdle",     {63'b0, bus.in_ready},  64'd1);
        checkOutput("bpValidLow", {63'b0, bus.out_valid}, 64'd0);

        // Flush together with in_valid in IDLE drops the request.
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.div_op   = 2'b01;
        bus.input_div_A = 64'd50;
        bus.input_div_B = 64'd5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        checkOutput("flushIdleReady", {63'b0, bus.in_ready}, 64'd1);
        checkOutput("flushIdleBusy",  {63'b0, bus.div_busy}, 64'd0);

        // Flush mid-operation.
        applyStimulus(2'b01, 1'b0, 64'd100, 64'd7);
        checkOutput("calcBusy",  {63'b0, bus.div_busy}, 64'd1);
        checkOutput("calcReady", {63'b0, bus.in_ready}, 64'd0);
        repeat (19) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checkOutput("flushReady",  {63'b0, bus.in_ready}, 64'd1);
        checkOutput("flushResult", bus.div_result, 64'd5);
        saw = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            saw = saw | bus.out_valid;
        end
        checkOutput("flushNoValid", {63'b0, saw}, 64'd0);
        runOp("flushNext", 2'b01, 1'b0, 64'd9, 64'd3, 64'd3, 66);

        // Reset mid-operation.
        applyStimulus(2'b01, 1'b0, 64'd100, 64'd7);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstMidReady",  {63'b0, bus.in_ready}, 64'd1);
        checkOutput("rstMidBusy",   {63'b0, bus.div_busy}, 64'd0);
        checkOutput("rstMidResult", bus.div_result, 64'd0);
        saw = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            saw = saw | bus.out_valid;
        end
        checkOutput("rstNoValid", {63'b0, saw}, 64'd0);
        runOp("rstNext", 2'b01, 1'b0, 64'd9, 64'd3, 64'd3, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
